mc_main_control: RTL

- Multi-cycle main control FSM for the MIPS datapath. Sits directly upstream of the ALU control stage and supplies its 2-bit alu_op.
- Decodes the 6-bit instruction opcode. Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives all datapath mux selects and write enables. Stalls on a memory ready handshake with a timeout.

---
 rtl/mc_main_control_pkg.sv | 41 ++++
 rtl/mc_main_control_if.sv | 37 +++
 rtl/mc_main_control_wait_timer.sv | 27 ++
 rtl/mc_main_control.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mc_main_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: opcodes, ALU op,
// mux-select codes and FSM state numbering.
// Latency: n/a (constants only). Backpressure: n/a.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_SRC_B_REG   = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM   = 2'b10;
    localparam logic [1:0] ALU_SRC_B_SHIMM = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

endpackage

// File: rtl/mc_main_control_if.sv
// Bundle between the main control FSM and the datapath it steers.
// Latency: n/a (wires only). Backpressure: mem_ready from memory stalls the FSM.
// master = control side (drives selects/enables), slave = datapath side.
interface mc_main_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] state_o;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_err, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_err, state_o
    );
endinterface

// File: rtl/mc_main_control_wait_timer.sv
// Memory-wait counter: counts stalled cycles, flags when MEM_TIMEOUT is reached.
// Latency: expired is a registered-count compare, valid the cycle the count lands.
// Backpressure: none; clr wins over en, count saturates at MEM_TIMEOUT.
// Ports: clk, rst_n, clr (zero the count), en (count this cycle), expired.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8   // 2**CNT_W must exceed MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: one state per cycle; memory states hold until mem_ready or MEM_TIMEOUT.
// Backpressure: mem_ready=0 stalls FETCH/MEM_READ/MEM_WRITE; timeout aborts to FETCH.
// Ports: clk, rst_n (async active-low), bus (mc_main_control_if.master: opcode,
// mem_ready in; selects, enables, alu_op, illegal_op, mem_err, state_o out).
// Build option: CTRL_ADDI_EN adds the addi path (ADDI_EXEC/ADDI_WB).
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mc_main_control_if.master   bus
);
    state_t state, next_state;
    logic   waiting, expired, timeout, timer_clr, timer_en;

    logic       pc_write_s, ir_write_s, reg_write_s, mem_write_s;
    logic       pc_write_cond_s, i_or_d_s, mem_read_s, mem_to_reg_s, reg_dst_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

    assign waiting   = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign timeout   = waiting && expired && !bus.mem_ready;
    // Any state change clears the count, so every wait state starts from zero;
    // a FETCH timeout re-enters FETCH without a state change, hence the explicit term.
    assign timer_clr = (next_state != state) || timeout;
    assign timer_en  = waiting && !bus.mem_ready;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:     if (bus.mem_ready) next_state = S_DECODE;
                         else if (timeout)  next_state = S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      next_state = S_ADDI_EXEC;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  if (bus.opcode == OP_LW)      next_state = S_MEM_READ;
                         else if (bus.opcode == OP_SW) next_state = S_MEM_WRITE;
                         else                          next_state = S_FETCH;
            S_MEM_READ:  if (bus.mem_ready) next_state = S_MEM_WB;
                         else if (timeout)  next_state = S_FETCH;
            S_MEM_WB:    next_state = S_FETCH;
            S_MEM_WRITE: if (bus.mem_ready || timeout) next_state = S_FETCH;
            S_EXECUTE:   next_state = S_R_WB;
            S_R_WB:      next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_JUMP:      next_state = S_FETCH;
`ifdef CTRL_ADDI_EN
            S_ADDI_EXEC: next_state = S_ADDI_WB;
            S_ADDI_WB:   next_state = S_FETCH;
`endif
            default:     next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        i_or_d_s        = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = ALU_SRC_B_REG;
        alu_op_s        = ALU_OP_ADD;
        pc_source_s     = PC_SRC_ALU;
        case (state)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = ALU_SRC_B_FOUR;
                // IR/PC only load on the cycle memory actually returns the word
                ir_write_s  = bus.mem_ready;
                pc_write_s  = bus.mem_ready;
            end
            S_DECODE:    alu_src_b_s = ALU_SRC_B_SHIMM;
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = ALU_SRC_B_IMM;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                i_or_d_s    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = ALU_OP_SUB;
                pc_write_cond_s = 1'b1;
                pc_source_s     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = PC_SRC_JUMP;
            end
`ifdef CTRL_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = ALU_SRC_B_IMM;
            end
            S_ADDI_WB:   reg_write_s = 1'b1;
`endif
            default: ;
        endcase
    end

    // Write enables and pulses are gated by rst_n directly so nothing can
    // commit between the async reset edge and the next clock.
    assign bus.pc_write      = rst_n & pc_write_s;
    assign bus.ir_write      = rst_n & ir_write_s;
    assign bus.reg_write     = rst_n & reg_write_s;
    assign bus.mem_write     = rst_n & mem_write_s;
    assign bus.illegal_op    = rst_n & (state == S_DECODE) & (next_state == S_FETCH);
    assign bus.mem_err       = rst_n & timeout;
    assign bus.pc_write_cond = pc_write_cond_s;
    assign bus.i_or_d        = i_or_d_s;
    assign bus.mem_read      = mem_read_s;
    assign bus.mem_to_reg    = mem_to_reg_s;
    assign bus.reg_dst       = reg_dst_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.pc_source     = pc_source_s;
    assign bus.state_o       = state;
endmodule
